// File: rtl/cga_alu_pkg.sv
// Shared types and constants for the CGA ALU datapath.
package cga_alu_pkg;

  localparam int unsigned REGFILE_DEPTH = 16;

  typedef enum logic [2:0] {
    DestQreg  = 3'd0,
    DestNop   = 3'd1,
    DestRama  = 3'd2,
    DestRamf  = 3'd3,
    DestRamqd = 3'd4,
    DestRamd  = 3'd5,
    DestRamqu = 3'd6,
    DestRamu  = 3'd7
  } dest_t;

endpackage

// File: rtl/cga_alu_regfile.sv
// 16x16 working register file: two asynchronous read ports, one synchronous
// write port, synchronous clear.
module cga_alu_regfile
  import cga_alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [3:0]  raddr_a_i,
  input  logic [3:0]  raddr_b_i,
  output logic [15:0] rdata_a_o,
  output logic [15:0] rdata_b_o
);

  logic [15:0] mem_q [REGFILE_DEPTH];
  logic [15:0] mem_d [REGFILE_DEPTH];

  always_comb begin
    for (int i = 0; i < REGFILE_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < REGFILE_DEPTH; i++) begin
      if (rst_i) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // No write-through: a same-cycle read returns the pre-write contents.
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/cga_alu_dest.sv
// CGA ALU destination stage: decodes DEST, shifts F/Q and writes the
// register file and Q register; drives the Y bus and shift-out pins.
module cga_alu_dest
  import cga_alu_pkg::*;
(
  input  logic        sysclk,
  input  logic        sys_rst,
  input  logic        CE,
  input  logic [2:0]  DEST_2_0,
  input  logic [3:0]  A_3_0,
  input  logic [3:0]  B_3_0,
  input  logic [15:0] F_15_0,
  input  logic        RSI_DN,
  input  logic        RSI_UP,
  input  logic        QSI_DN,
  input  logic        QSI_UP,
  output logic [15:0] A_15_0,
  output logic [15:0] B_15_0,
  output logic [15:0] Q_15_0,
  output logic [15:0] Y_15_0,
  output logic        RSO_DN,
  output logic        RSO_UP,
  output logic        QSO_DN,
  output logic        QSO_UP
);

  dest_t       dest;
  logic [15:0] q_q, q_d;
  logic [15:0] rf_a, rf_b;
  logic [15:0] rf_wdata;
  logic        rf_wr;
  logic        rf_we;
  logic [15:0] q_next;

  assign dest = dest_t'(DEST_2_0);

  always_comb begin
    rf_wr    = 1'b0;
    rf_wdata = F_15_0;
    q_next   = q_q;
    Y_15_0   = F_15_0;
    unique case (dest)
      DestQreg:  q_next = F_15_0;
      DestNop:   ;
      DestRama: begin
        rf_wr  = 1'b1;
        Y_15_0 = rf_a;
      end
      DestRamf:  rf_wr = 1'b1;
      DestRamqd: begin
        rf_wr    = 1'b1;
        rf_wdata = {RSI_DN, F_15_0[15:1]};
        q_next   = {QSI_DN, q_q[15:1]};
      end
      DestRamd: begin
        rf_wr    = 1'b1;
        rf_wdata = {RSI_DN, F_15_0[15:1]};
      end
      DestRamqu: begin
        rf_wr    = 1'b1;
        rf_wdata = {F_15_0[14:0], RSI_UP};
        q_next   = {q_q[14:0], QSI_UP};
      end
      DestRamu: begin
        rf_wr    = 1'b1;
        rf_wdata = {F_15_0[14:0], RSI_UP};
      end
      default: ;
    endcase
  end

  // CE gates state updates only; Y and shift-outs stay live.
  assign rf_we = rf_wr & CE;
  assign q_d   = CE ? q_next : q_q;

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  cga_alu_regfile u_regfile (
    .clk_i     (sysclk),
    .rst_i     (sys_rst),
    .we_i      (rf_we),
    .waddr_i   (B_3_0),
    .wdata_i   (rf_wdata),
    .raddr_a_i (A_3_0),
    .raddr_b_i (B_3_0),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  assign A_15_0 = rf_a;
  assign B_15_0 = rf_b;
  assign Q_15_0 = q_q;
  assign RSO_DN = F_15_0[0];
  assign RSO_UP = F_15_0[15];
  assign QSO_DN = q_q[0];
  assign QSO_UP = q_q[15];

endmodule

// File: tb/tb_cga_alu_dest.sv
// Bench for cga_alu_dest: vector table of pre-edge expectations, checked
// through a scoreboard queue, plus collision and reset corner sequences.
module tb_cga_alu_dest;

  logic        sysclk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        CE = 1'b0;
  logic [2:0]  DEST_2_0 = '0;
  logic [3:0]  A_3_0 = '0;
  logic [3:0]  B_3_0 = '0;
  logic [15:0] F_15_0 = '0;
  logic        RSI_DN = 1'b0;
  logic        RSI_UP = 1'b0;
  logic        QSI_DN = 1'b0;
  logic        QSI_UP = 1'b0;
  logic [15:0] A_15_0, B_15_0, Q_15_0, Y_15_0;
  logic        RSO_DN, RSO_UP, QSO_DN, QSO_UP;

  cga_alu_dest dut (
    .sysclk   (sysclk),
    .sys_rst  (sys_rst),
    .CE       (CE),
    .DEST_2_0 (DEST_2_0),
    .A_3_0    (A_3_0),
    .B_3_0    (B_3_0),
    .F_15_0   (F_15_0),
    .RSI_DN   (RSI_DN),
    .RSI_UP   (RSI_UP),
    .QSI_DN   (QSI_DN),
    .QSI_UP   (QSI_UP),
    .A_15_0   (A_15_0),
    .B_15_0   (B_15_0),
    .Q_15_0   (Q_15_0),
    .Y_15_0   (Y_15_0),
    .RSO_DN   (RSO_DN),
    .RSO_UP   (RSO_UP),
    .QSO_DN   (QSO_DN),
    .QSO_UP   (QSO_UP)
  );

  always #5 sysclk = ~sysclk;

  // Inputs applied for one edge; expectations are the outputs seen just
  // before that edge. si = {RSI_DN,RSI_UP,QSI_DN,QSI_UP},
  // so = {RSO_DN,RSO_UP,QSO_DN,QSO_UP}.
  typedef struct {
    logic        chk;
    logic        rst;
    logic        ce;
    logic [2:0]  dest;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] f;
    logic [3:0]  si;
    logic [15:0] y;
    logic [15:0] ao;
    logic [15:0] bo;
    logic [15:0] q;
    logic [3:0]  so;
  } vec_t;

  vec_t        tbl [16];
  logic [67:0] exp_q [$];
  string       tag_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic chk, input logic rst, input logic ce,
                              input logic [2:0] dest, input logic [3:0] a,
                              input logic [3:0] b, input logic [15:0] f,
                              input logic [3:0] si, input logic [15:0] y,
                              input logic [15:0] ao, input logic [15:0] bo,
                              input logic [15:0] q, input logic [3:0] so);
    vec_t v;
    v.chk = chk; v.rst = rst; v.ce = ce; v.dest = dest; v.a = a; v.b = b;
    v.f = f; v.si = si; v.y = y; v.ao = ao; v.bo = bo; v.q = q; v.so = so;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [67:0] e;
    logic [67:0] got;
    @(negedge sysclk);
    sys_rst  = v.rst;
    CE       = v.ce;
    DEST_2_0 = v.dest;
    A_3_0    = v.a;
    B_3_0    = v.b;
    F_15_0   = v.f;
    {RSI_DN, RSI_UP, QSI_DN, QSI_UP} = v.si;
    if (v.chk) begin
      exp_q.push_back({v.y, v.ao, v.bo, v.q, v.so});
      tag_q.push_back(tag);
    end
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      got = {Y_15_0, A_15_0, B_15_0, Q_15_0, RSO_DN, RSO_UP, QSO_DN, QSO_UP};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: got Y=%h A=%h B=%h Q=%h so=%b, want Y=%h A=%h B=%h Q=%h so=%b",
                 tag, got[67:52], got[51:36], got[35:20], got[19:4], got[3:0],
                 e[67:52], e[51:36], e[35:20], e[19:4], e[3:0]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    //          chk rst ce dest a  b  f        si       y        ao       bo       q        so
    tbl[0]  = mk(0, 1, 1, 3, 0, 0, 16'hFFFF, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
    tbl[1]  = mk(1, 0, 1, 3, 0, 5, 16'h1234, 4'b0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
    tbl[2]  = mk(1, 0, 1, 2, 5, 6, 16'h00FF, 4'b0000, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 4'b1000);
    tbl[3]  = mk(1, 0, 0, 0, 6, 5, 16'hA5A5, 4'b0000, 16'hA5A5, 16'h00FF, 16'h1234, 16'h0000, 4'b1100);
    tbl[4]  = mk(1, 0, 1, 0, 6, 5, 16'hA5A5, 4'b0000, 16'hA5A5, 16'h00FF, 16'h1234, 16'h0000, 4'b1100);
    tbl[5]  = mk(1, 0, 1, 1, 6, 5, 16'h0000, 4'b0000, 16'h0000, 16'h00FF, 16'h1234, 16'hA5A5, 4'b0011);
    tbl[6]  = mk(1, 0, 1, 0, 0, 0, 16'h0003, 4'b0000, 16'h0003, 16'h0000, 16'h0000, 16'hA5A5, 4'b1011);
    tbl[7]  = mk(1, 0, 1, 4, 2, 2, 16'h8001, 4'b1000, 16'h8001, 16'h0000, 16'h0000, 16'h0003, 4'b1110);
    tbl[8]  = mk(1, 0, 1, 1, 2, 7, 16'h0000, 4'b0000, 16'h0000, 16'hC000, 16'h0000, 16'h0001, 4'b0010);
    tbl[9]  = mk(1, 0, 1, 0, 2, 7, 16'h8000, 4'b0000, 16'h8000, 16'hC000, 16'h0000, 16'h0001, 4'b0110);
    tbl[10] = mk(1, 0, 1, 6, 7, 7, 16'h4001, 4'b0001, 16'h4001, 16'h0000, 16'h0000, 16'h8000, 4'b1001);
    tbl[11] = mk(1, 0, 1, 5, 7, 3, 16'h0003, 4'b0000, 16'h0003, 16'h8002, 16'h0000, 16'h0001, 4'b1010);
    tbl[12] = mk(1, 0, 1, 7, 3, 4, 16'h8000, 4'b0100, 16'h8000, 16'h0001, 16'h0000, 16'h0001, 4'b0110);
    tbl[13] = mk(1, 0, 1, 1, 4, 3, 16'hFFFE, 4'b0000, 16'hFFFE, 16'h0001, 16'h0001, 16'h0001, 4'b0110);
    tbl[14] = mk(1, 0, 0, 4, 4, 4, 16'hFFFF, 4'b1010, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001, 4'b1110);
    tbl[15] = mk(1, 0, 1, 1, 4, 4, 16'h0000, 4'b0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 4'b0010);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], $sformatf("table[%0d]", i));
    end

    // Same-address collision: old value during the write cycle, new one after.
    apply(mk(1, 0, 1, 3, 9, 9, 16'h1111, 4'b0000, 16'h1111, 16'h0000, 16'h0000, 16'h0001, 4'b1010),
          "coll_seed");
    apply(mk(1, 0, 1, 3, 9, 9, 16'h2222, 4'b0000, 16'h2222, 16'h1111, 16'h1111, 16'h0001, 4'b0010),
          "coll_write_cycle");
    apply(mk(1, 0, 0, 1, 9, 9, 16'h0000, 4'b0000, 16'h0000, 16'h2222, 16'h2222, 16'h0001, 4'b0010),
          "coll_next_cycle");

    // Reset mid-sequence with a live RAMF write to RF[2]: write must be dropped.
    apply(mk(1, 1, 1, 3, 9, 2, 16'h5555, 4'b0000, 16'h5555, 16'h2222, 16'hC000, 16'h0001, 4'b1010),
          "rst_mid");
    for (int i = 0; i < 16; i++) begin
      apply(mk(1, 0, 0, 1, i[3:0], 4'(15 - i), 16'h0000, 4'b0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000),
            $sformatf("post_rst_addr[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
